// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retire, CDB capture, mispredict flush
// and operand lookup with same-cycle CDB bypass.
module reorder_buffer #(
  parameter int ROB_SIZE_WIDTH = 3,
  parameter int XLEN           = 32,
  parameter int REG_CNT_WIDTH  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      stall,
  input  logic                      dec_ready,
  input  logic [1:0]                dec_type,
  input  logic [REG_CNT_WIDTH-1:0]  dec_rd,
  input  logic                      dec_pred_jump,
  input  logic [XLEN-1:0]           dec_alt_pc,
  input  logic                      cdb_enable,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id,
  input  logic [XLEN-1:0]           cdb_val,
  input  logic                      cdb_jump,
  input  logic [ROB_SIZE_WIDTH-1:0] qry_id1,
  input  logic [ROB_SIZE_WIDTH-1:0] qry_id2,
  output logic                      qry_ready1,
  output logic                      qry_ready2,
  output logic [XLEN-1:0]           qry_val1,
  output logic [XLEN-1:0]           qry_val2,
  output logic                      rob_rf_enable,
  output logic [REG_CNT_WIDTH-1:0]  rob_rf_rd,
  output logic [XLEN-1:0]           rob_rf_val,
  output logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
  output logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
  output logic                      rob_full,
  output logic                      rob_store_commit,
  output logic                      rob_flush,
  output logic [XLEN-1:0]           rob_flush_pc
);

  localparam int ROB_SIZE = 1 << ROB_SIZE_WIDTH;
  localparam logic [ROB_SIZE_WIDTH:0] CNT_FULL = (ROB_SIZE_WIDTH+1)'(ROB_SIZE);
  localparam logic [ROB_SIZE_WIDTH:0] CNT_ONE  = (ROB_SIZE_WIDTH+1)'(1);
  localparam logic [ROB_SIZE_WIDTH-1:0] ID_ONE = ROB_SIZE_WIDTH'(1);
  localparam logic [1:0] T_REG = 2'd0;
  localparam logic [1:0] T_BR  = 2'd1;
  localparam logic [1:0] T_ST  = 2'd2;
  localparam logic [1:0] T_NOP = 2'd3;

  logic [ROB_SIZE-1:0]      busy_q;
  logic [ROB_SIZE-1:0]      ready_q;
  logic [ROB_SIZE-1:0]      pred_q;
  logic [ROB_SIZE-1:0]      mis_q;
  logic [1:0]               kind_q [ROB_SIZE];
  logic [REG_CNT_WIDTH-1:0] rd_q   [ROB_SIZE];
  logic [XLEN-1:0]          val_q  [ROB_SIZE];
  logic [XLEN-1:0]          alt_q  [ROB_SIZE];

  logic [ROB_SIZE_WIDTH-1:0] head_q, head_d;
  logic [ROB_SIZE_WIDTH-1:0] tail_q, tail_d;
  logic [ROB_SIZE_WIDTH:0]   count_q, count_d;

  logic                     rf_en_q;
  logic [REG_CNT_WIDTH-1:0] rf_rd_q;
  logic [XLEN-1:0]          rf_val_q;
  logic                     store_q;
  logic                     flush_q;
  logic [XLEN-1:0]          flush_pc_q;

  logic       full;
  logic       do_disp;
  logic       do_cdb;
  logic       do_commit;
  logic       do_flush;
  logic [1:0] head_kind;
  logic       head_wr;

  // Full is judged before commit, so a slot freed this edge is not reusable yet
  assign full      = (count_q == CNT_FULL);
  assign do_disp   = dec_ready && !stall && !full;
  assign do_cdb    = cdb_enable && busy_q[cdb_rob_id];
  assign do_commit = busy_q[head_q] && ready_q[head_q];
  assign head_kind = kind_q[head_q];
  assign do_flush  = do_commit && (head_kind == T_BR) && mis_q[head_q];
  assign head_wr   = (head_kind == T_REG || head_kind == T_NOP)
                     && (rd_q[head_q] != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_commit) head_d = head_q + ID_ONE;
      if (do_disp)   tail_d = tail_q + ID_ONE;
      unique case ({do_disp, do_commit})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        busy_q     <= '0;
        ready_q    <= '0;
        rf_en_q    <= 1'b0;
        rf_rd_q    <= '0;
        rf_val_q   <= '0;
        store_q    <= 1'b0;
        flush_q    <= 1'b0;
        flush_pc_q <= '0;
      end else begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        if (do_flush) begin
          busy_q  <= '0;
          ready_q <= '0;
        end else begin
          if (do_commit) begin
            busy_q[head_q]  <= 1'b0;
            ready_q[head_q] <= 1'b0;
          end
          if (do_disp) begin
            busy_q[tail_q]  <= 1'b1;
            ready_q[tail_q] <= 1'b0;
            kind_q[tail_q]  <= dec_type;
            rd_q[tail_q]    <= dec_rd;
            pred_q[tail_q]  <= dec_pred_jump;
            alt_q[tail_q]   <= dec_alt_pc;
          end
          if (do_cdb) begin
            ready_q[cdb_rob_id] <= 1'b1;
            val_q[cdb_rob_id]   <= cdb_val;
            mis_q[cdb_rob_id]   <= (cdb_jump != pred_q[cdb_rob_id]);
          end
        end
        rf_en_q <= do_commit && head_wr;
        store_q <= do_commit && (head_kind == T_ST);
        flush_q <= do_flush;
        if (do_commit) begin
          rf_rd_q  <= rd_q[head_q];
          rf_val_q <= val_q[head_q];
        end
        if (do_flush) flush_pc_q <= alt_q[head_q];
      end
    end
  end

  always_comb begin
    qry_ready1 = busy_q[qry_id1] && ready_q[qry_id1];
    qry_val1   = val_q[qry_id1];
    qry_ready2 = busy_q[qry_id2] && ready_q[qry_id2];
    qry_val2   = val_q[qry_id2];
    if (cdb_enable && cdb_rob_id == qry_id1) begin
      qry_ready1 = 1'b1;
      qry_val1   = cdb_val;
    end
    if (cdb_enable && cdb_rob_id == qry_id2) begin
      qry_ready2 = 1'b1;
      qry_val2   = cdb_val;
    end
  end

  assign rob_rf_enable    = rf_en_q;
  assign rob_rf_rd        = rf_rd_q;
  assign rob_rf_val       = rf_val_q;
  assign rob_head_id      = head_q;
  assign rob_tail_id      = tail_q;
  assign rob_full         = full;
  assign rob_store_commit = store_q;
  assign rob_flush        = flush_q;
  assign rob_flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed dispatch/CDB sequences,
// commit pulses checked by an independent monitor.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy, stall, dec_ready, dec_pred_jump;
  logic [1:0]  dec_type;
  logic [4:0]  dec_rd;
  logic [31:0] dec_alt_pc;
  logic        cdb_enable, cdb_jump;
  logic [2:0]  cdb_rob_id, qry_id1, qry_id2;
  logic [31:0] cdb_val;
  logic        qry_ready1, qry_ready2;
  logic [31:0] qry_val1, qry_val2;
  logic        rob_rf_enable, rob_full, rob_store_commit, rob_flush;
  logic [4:0]  rob_rf_rd;
  logic [31:0] rob_rf_val, rob_flush_pc;
  logic [2:0]  rob_head_id, rob_tail_id;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall),
    .dec_ready(dec_ready), .dec_type(dec_type), .dec_rd(dec_rd),
    .dec_pred_jump(dec_pred_jump), .dec_alt_pc(dec_alt_pc),
    .cdb_enable(cdb_enable), .cdb_rob_id(cdb_rob_id),
    .cdb_val(cdb_val), .cdb_jump(cdb_jump),
    .qry_id1(qry_id1), .qry_id2(qry_id2),
    .qry_ready1(qry_ready1), .qry_ready2(qry_ready2),
    .qry_val1(qry_val1), .qry_val2(qry_val2),
    .rob_rf_enable(rob_rf_enable), .rob_rf_rd(rob_rf_rd),
    .rob_rf_val(rob_rf_val), .rob_head_id(rob_head_id),
    .rob_tail_id(rob_tail_id), .rob_full(rob_full),
    .rob_store_commit(rob_store_commit), .rob_flush(rob_flush),
    .rob_flush_pc(rob_flush_pc)
  );

  always #5 clk = ~clk;

  // kind bits: {flush, store, rf}
  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [2:0]  head;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(logic [2:0] k, logic [4:0] rd,
                              logic [31:0] v, logic [2:0] h);
    exp_t e;
    e.kind = k; e.rd = rd; e.val = v; e.head = h;
    return e;
  endfunction

  exp_t       m_e;
  logic [2:0] m_kind;
  logic       m_bad;

  always @(negedge clk) begin
    if (rob_rf_enable || rob_store_commit || rob_flush) begin
      m_kind = {rob_flush, rob_store_commit, rob_rf_enable};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected kind=%b head=%0d rd=%0d val=%h",
                 m_kind, rob_head_id, rob_rf_rd, rob_rf_val);
      end else begin
        m_e = sb.pop_front();
        m_bad = (m_kind != m_e.kind) || (rob_head_id != m_e.head);
        if (m_e.kind == 3'b001)
          m_bad = m_bad || (rob_rf_rd != m_e.rd) || (rob_rf_val != m_e.val);
        if (m_e.kind == 3'b100)
          m_bad = m_bad || (rob_flush_pc != m_e.val);
        if (m_bad) begin
          errors++;
          $display("FAIL sb_commit got kind=%b head=%0d rd=%0d val=%h pc=%h want kind=%b head=%0d rd=%0d val=%h",
                   m_kind, rob_head_id, rob_rf_rd, rob_rf_val, rob_flush_pc,
                   m_e.kind, m_e.head, m_e.rd, m_e.val);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_ready = 1'b0;
    cdb_enable = 1'b0;
  endtask

  task automatic disp(logic [1:0] t, logic [4:0] rd,
                      logic pj, logic [31:0] alt);
    dec_ready = 1'b1; dec_type = t; dec_rd = rd;
    dec_pred_jump = pj; dec_alt_pc = alt;
  endtask

  task automatic cdb(logic [2:0] id, logic [31:0] v, logic j);
    cdb_enable = 1'b1; cdb_rob_id = id; cdb_val = v; cdb_jump = j;
  endtask

  task automatic do_reset();
    idle();
    rdy = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; stall = 1'b0;
    dec_ready = 1'b0; dec_type = '0; dec_rd = '0;
    dec_pred_jump = 1'b0; dec_alt_pc = '0;
    cdb_enable = 1'b0; cdb_rob_id = '0; cdb_val = '0; cdb_jump = 1'b0;
    qry_id1 = '0; qry_id2 = '0;

    // basic writeback
    do_reset();
    chk("rst_head", rob_head_id, 0);
    chk("rst_tail", rob_tail_id, 0);
    chk("rst_full", rob_full, 0);
    chk("rst_rf_en", rob_rf_enable, 0);
    chk("rst_flush", rob_flush, 0);
    disp(2'd0, 5'd5, 1'b0, 32'h0);
    step();
    idle();
    chk("t1_tail", rob_tail_id, 1);
    cdb(3'd0, 32'd7, 1'b0);
    sb.push_back(mk(3'b001, 5'd5, 32'd7, 3'd1));
    step();
    idle();
    step();
    step();
    chk("t1_head", rob_head_id, 1);

    // fill, ignored 9th, no reuse of same-edge freed slot
    do_reset();
    for (int i = 0; i < 8; i++) begin
      disp(2'd0, 5'(i + 1), 1'b0, 32'h0);
      step();
    end
    chk("t2_full", rob_full, 1);
    chk("t2_tail", rob_tail_id, 0);
    disp(2'd0, 5'd9, 1'b0, 32'h0);
    step();
    chk("t2_9th_tail", rob_tail_id, 0);
    idle();
    cdb(3'd0, 32'h11, 1'b0);
    sb.push_back(mk(3'b001, 5'd1, 32'h11, 3'd1));
    step();
    idle();
    disp(2'd0, 5'd9, 1'b0, 32'h0);
    step();
    chk("t2_unfull", rob_full, 0);
    chk("t2_nodisp_tail", rob_tail_id, 0);
    step();
    idle();
    chk("t2_refill_tail", rob_tail_id, 1);
    chk("t2_refull", rob_full, 1);

    // out-of-order completion, in-order retire
    do_reset();
    disp(2'd0, 5'd3, 1'b0, 32'h0); step();
    disp(2'd3, 5'd4, 1'b0, 32'h0); step();
    disp(2'd0, 5'd0, 1'b0, 32'h0); step();
    idle();
    cdb(3'd2, 32'h22, 1'b0); step();
    cdb(3'd1, 32'h21, 1'b0); step();
    cdb(3'd0, 32'h20, 1'b0);
    sb.push_back(mk(3'b001, 5'd3, 32'h20, 3'd1));
    sb.push_back(mk(3'b001, 5'd4, 32'h21, 3'd2));
    step();
    idle();
    step(); step(); step();
    chk("t3_head", rob_head_id, 3);
    chk("t3_tail", rob_tail_id, 3);

    // mispredicted branch flush
    do_reset();
    disp(2'd1, 5'd0, 1'b0, 32'h100); step();
    disp(2'd0, 5'd7, 1'b0, 32'h0); step();
    disp(2'd0, 5'd8, 1'b0, 32'h0); step();
    idle();
    cdb(3'd1, 32'd1, 1'b0); step();
    cdb(3'd0, 32'd0, 1'b1); step();
    disp(2'd0, 5'd9, 1'b0, 32'h0);
    cdb(3'd2, 32'd5, 1'b0);
    sb.push_back(mk(3'b100, 5'd0, 32'h100, 3'd0));
    step();
    idle();
    chk("t4_head", rob_head_id, 0);
    chk("t4_tail", rob_tail_id, 0);
    chk("t4_full", rob_full, 0);
    qry_id1 = 3'd1;
    #1;
    chk("t4_qry_flushed", qry_ready1, 0);
    step(); step(); step();

    // nop, good branch, reg write, store
    do_reset();
    disp(2'd3, 5'd0, 1'b0, 32'h0); step();
    disp(2'd1, 5'd0, 1'b1, 32'h200); step();
    disp(2'd0, 5'd2, 1'b0, 32'h0); step();
    disp(2'd2, 5'd0, 1'b0, 32'h0); step();
    idle();
    cdb(3'd0, 32'h99, 1'b0); step();
    cdb(3'd1, 32'h0, 1'b1); step();
    cdb(3'd2, 32'd5, 1'b0); step();
    cdb(3'd3, 32'hABC, 1'b0);
    sb.push_back(mk(3'b001, 5'd2, 32'd5, 3'd3));
    sb.push_back(mk(3'b010, 5'd0, 32'h0, 3'd4));
    step();
    idle();
    step(); step(); step();
    chk("t5_head", rob_head_id, 4);

    // queries, bypass, freeze, mid-stream reset
    do_reset();
    disp(2'd0, 5'd1, 1'b0, 32'h0); step();
    disp(2'd0, 5'd2, 1'b0, 32'h0); step();
    idle();
    qry_id1 = 3'd1; qry_id2 = 3'd0;
    #1;
    chk("t6_qry_notready", qry_ready1, 0);
    cdb(3'd1, 32'hDEAD, 1'b0);
    #1;
    chk("t6_byp_ready", qry_ready1, 1);
    chk("t6_byp_val", qry_val1, 32'hDEAD);
    chk("t6_qry2_notready", qry_ready2, 0);
    step();
    idle();
    #1;
    chk("t6_held_ready", qry_ready1, 1);
    chk("t6_held_val", qry_val1, 32'hDEAD);
    rdy = 1'b0;
    cdb(3'd0, 32'h55, 1'b0);
    step(); step();
    idle();
    rdy = 1'b1;
    #1;
    chk("t6_freeze_cdb", qry_ready2, 0);
    chk("t6_freeze_tail", rob_tail_id, 2);
    cdb(3'd0, 32'd9, 1'b0); step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_head", rob_head_id, 0);
    chk("t6_rst_tail", rob_tail_id, 0);
    chk("t6_rst_rf_en", rob_rf_enable, 0);
    chk("t6_rst_rf_rd", rob_rf_rd, 0);
    chk("t6_rst_rf_val", rob_rf_val, 0);
    chk("t6_rst_store", rob_store_commit, 0);
    chk("t6_rst_flush", rob_flush, 0);
    chk("t6_rst_pc", rob_flush_pc, 0);
    chk("t6_rst_qry", qry_ready1, 0);
    step(); step();

    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
